// File: rtl/trig_phase_align.sv
// trig_phase_align: confirms per-channel phase flags from the sync/histogram
// stage across consecutive sync windows, commits a 2-bit phase per channel, and
// delays each coax trigger so that all channels land in the same clk_adc bin.
module trig_phase_align #(
  parameter int unsigned NCH     = 16,
  parameter int unsigned CONFIRM = 2,
  parameter int unsigned MAXDLY  = 3
) (
  input  logic                 clk_adc,
  input  logic                 rst,
  input  logic                 spareright,
  input  logic [8*NCH-1:0]     delaycounter,
  input  logic [NCH-1:0]       coax_in,
  output logic [NCH-1:0]       trig_out,
  output logic [2*NCH-1:0]     phase_sel,
  output logic [NCH-1:0]       neg_edge,
  output logic [NCH-1:0]       phase_valid,
  output logic                 cal_done,
  output logic [NCH-1:0]       cal_err
);

  localparam int unsigned CW = 3;
  localparam int unsigned MW = $clog2(MAXDLY + 2);
  localparam int unsigned TW = (MAXDLY > 1) ? $clog2(MAXDLY + 1) : 1;
  localparam logic [CW-1:0] CONFIRM_V = CW'(CONFIRM);
  localparam logic [MW-1:0] MASK_LEN  = MW'(MAXDLY + 1);

  typedef enum logic [1:0] {IDLE, WINDOW, EVAL} state_t;

  state_t                      state;
  logic [8*NCH-1:0]            samp;
  logic [NCH-1:0][1:0]         cand;
  logic [NCH-1:0]              cneg;
  logic [NCH-1:0][CW-1:0]      cnt;
  logic [MW-1:0]               mask_cnt;
  logic [NCH-1:0][MAXDLY-1:0]  dly;

  logic [NCH-1:0]              one_c;
  logic [NCH-1:0][2:0]         idx_c;
  logic [NCH-1:0]              match_c;
  logic [NCH-1:0][CW-1:0]      cnt_new_c;
  logic [NCH-1:0][MAXDLY:0]    taps_c;
  logic [NCH-1:0][TW-1:0]      tidx_c;
  logic [NCH-1:0]              tap_c;
  logic                        mask_next_c;

  // Decode the sampled flag byte of each channel and compute its next confirm count.
  always_comb begin
    one_c     = '0;
    idx_c     = '0;
    match_c   = '0;
    cnt_new_c = '0;
    for (int j = 0; j < NCH; j++) begin
      one_c[j] = ($countones(samp[8*j +: 8]) == 1);
      for (int k = 0; k < 8; k++) begin
        if (samp[8*j + k]) idx_c[j] = 3'(k);
      end
      match_c[j] = (idx_c[j][1:0] == cand[j]) && (idx_c[j][2] == cneg[j]);
      if (!match_c[j])                cnt_new_c[j] = CW'(1);
      else if (cnt[j] >= CONFIRM_V)   cnt_new_c[j] = CONFIRM_V;
      else                            cnt_new_c[j] = cnt[j] + CW'(1);
    end
  end

  // Select the delay tap per channel: tap 0 is the live input, tap t is t cycles old.
  always_comb begin
    taps_c = '0;
    tidx_c = '0;
    tap_c  = '0;
    for (int j = 0; j < NCH; j++) begin
      taps_c[j] = {dly[j], coax_in[j]};
      tidx_c[j] = TW'(MAXDLY) - TW'(phase_sel[2*j +: 2]);
      tap_c[j]  = taps_c[j][tidx_c[j]];
    end
  end

  // Output is masked whenever the next cycle is inside a window, EVAL, or the flush tail.
  always_comb begin
    mask_next_c = spareright || (state != IDLE) || (mask_cnt > MW'(1));
  end

  // Window FSM, flag capture, per-channel confirm/commit and flush counter.
  always_ff @(posedge clk_adc) begin
    if (rst) begin
      state       <= IDLE;
      samp        <= '0;
      cand        <= '0;
      cneg        <= '0;
      cnt         <= '0;
      mask_cnt    <= '0;
      phase_sel   <= '0;
      neg_edge    <= '0;
      phase_valid <= '0;
      cal_done    <= 1'b0;
      cal_err     <= '0;
    end else begin
      cal_done <= 1'b0;
      if (state == EVAL)        mask_cnt <= MASK_LEN;
      else if (mask_cnt != '0)  mask_cnt <= mask_cnt - MW'(1);
      case (state)
        IDLE: begin
          if (spareright) state <= WINDOW;
        end
        WINDOW: begin
          if (!spareright) begin
            state    <= EVAL;
            samp     <= delaycounter;
            cal_done <= 1'b1;
          end
        end
        EVAL: begin
          state <= spareright ? WINDOW : IDLE;
          for (int j = 0; j < NCH; j++) begin
            if (one_c[j]) begin
              cal_err[j] <= 1'b0;
              cand[j]    <= idx_c[j][1:0];
              cneg[j]    <= idx_c[j][2];
              cnt[j]     <= cnt_new_c[j];
              if (cnt_new_c[j] == CONFIRM_V) begin
                phase_sel[2*j +: 2] <= idx_c[j][1:0];
                neg_edge[j]         <= idx_c[j][2];
                phase_valid[j]      <= 1'b1;
              end
            end else begin
              cal_err[j] <= 1'b1;
              cnt[j]     <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Per-channel trigger shift registers and masked, registered output tap.
  always_ff @(posedge clk_adc) begin
    if (rst) begin
      dly      <= '0;
      trig_out <= '0;
    end else begin
      for (int j = 0; j < NCH; j++) begin
        dly[j] <= taps_c[j][MAXDLY-1:0];
      end
      trig_out <= mask_next_c ? '0 : tap_c;
    end
  end

endmodule
